// File: rtl/field_renderer_if.sv
// Pixel-stream bundle between the raster source and field_renderer.
// The master drives pixel_valid, frame_start and field. The slave returns bgr_data and out_valid.
interface field_renderer_if #(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20,
    parameter int CBITS   = 3
);
    logic                               pixel_valid;
    logic                               frame_start;
    logic [FIELD_W*FIELD_H*CBITS-1:0]   field;
    logic [23:0]                        bgr_data;
    logic                               out_valid;

    modport master (output pixel_valid, frame_start, field, input bgr_data, out_valid);
    modport slave  (input pixel_valid, frame_start, field, output bgr_data, out_valid);
endinterface

// File: rtl/field_renderer.sv
// Two-stage field renderer that turns a raster pixel stream into {B,G,R} colour through a per-frame field snapshot.
// Optional GRID_LINES_EN draws a 202020 grid on the first row and column of each cell.
module field_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CELL     = 24,
    parameter int FIELD_W  = 20,
    parameter int FIELD_H  = 20,
    parameter int CBITS    = 3
) (
    input  logic           clk,
    input  logic           reset,
    field_renderer_if.slave bus
);
    localparam int PXW   = $clog2(H_ACTIVE);
    localparam int PYW   = $clog2(V_ACTIVE);
    localparam int SW    = $clog2(CELL);
    localparam int CXW   = $clog2(H_ACTIVE/CELL + 1);
    localparam int CYW   = $clog2(V_ACTIVE/CELL + 1);
    localparam int NCELL = FIELD_W*FIELD_H;
    localparam int IDXW  = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int FBITS = NCELL*CBITS;

    logic [PXW-1:0]   px, e_px, n_px;
    logic [PYW-1:0]   py, e_py, n_py;
    logic [SW-1:0]    sx, e_sx, n_sx, sy, e_sy, n_sy;
    logic [CXW-1:0]   cx, e_cx, n_cx;
    logic [CYW-1:0]   cy, e_cy, n_cy;
    logic [FBITS-1:0] snapshot;
    logic             eol, eof, x_end, y_end, in_field, in_panel;
    logic [IDXW-1:0]  cell_idx;

    logic             s1_valid, s1_in, s1_panel;
    logic [IDXW-1:0]  s1_idx;
`ifdef GRID_LINES_EN
    logic             s1_edge;
`endif
    logic [CBITS-1:0] cell_col;
    logic [23:0]      colour;

    function automatic logic [23:0] palette(input logic [2:0] c);
        case (c)
            3'd0:    palette = 24'h000000;
            3'd1:    palette = 24'h00aa00;
            3'd2:    palette = 24'haa0000;
            3'd3:    palette = 24'h0000aa;
            3'd4:    palette = 24'h00aaaa;
            3'd5:    palette = 24'haa00aa;
            3'd6:    palette = 24'haaaa00;
            default: palette = 24'haaaaaa;
        endcase
    endfunction

    // A qualified frame_start forces the current pixel to (0,0) regardless of counter state.
    always_comb begin
        e_px = bus.frame_start ? '0 : px;
        e_py = bus.frame_start ? '0 : py;
        e_sx = bus.frame_start ? '0 : sx;
        e_sy = bus.frame_start ? '0 : sy;
        e_cx = bus.frame_start ? '0 : cx;
        e_cy = bus.frame_start ? '0 : cy;

        eol   = (e_px == PXW'(H_ACTIVE-1));
        eof   = (e_py == PYW'(V_ACTIVE-1));
        x_end = (e_sx == SW'(CELL-1));
        y_end = (e_sy == SW'(CELL-1));

        n_px = eol ? '0 : e_px + PXW'(1);
        n_sx = (eol || x_end) ? '0 : e_sx + SW'(1);
        n_cx = eol ? '0 : (x_end ? e_cx + CXW'(1) : e_cx);
        n_py = e_py;
        n_sy = e_sy;
        n_cy = e_cy;
        if (eol) begin
            n_py = eof ? '0 : e_py + PYW'(1);
            n_sy = (eof || y_end) ? '0 : e_sy + SW'(1);
            n_cy = eof ? '0 : (y_end ? e_cy + CYW'(1) : e_cy);
        end

        in_field = (int'(e_px) < FIELD_W*CELL) && (int'(e_py) < FIELD_H*CELL);
        in_panel = (int'(e_px) >= FIELD_W*CELL);
        cell_idx = in_field ? IDXW'(int'(e_cy)*FIELD_W + int'(e_cx)) : '0;
    end

    // The snapshot loads on the frame_start edge, so stage 2 sees the live field for pixel (0,0).
    always_comb begin
        cell_col = snapshot[int'(s1_idx)*CBITS +: CBITS];
        if (s1_in)
            colour = palette(3'(cell_col));
        else if (s1_panel)
            colour = 24'h4f223b;
        else
            colour = 24'h000000;
`ifdef GRID_LINES_EN
        if (s1_in && s1_edge)
            colour = 24'h202020;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            px        <= '0;
            py        <= '0;
            sx        <= '0;
            sy        <= '0;
            cx        <= '0;
            cy        <= '0;
            snapshot  <= '0;
            s1_valid  <= 1'b0;
            s1_in     <= 1'b0;
            s1_panel  <= 1'b0;
            s1_idx    <= '0;
`ifdef GRID_LINES_EN
            s1_edge   <= 1'b0;
`endif
            bgr_reset();
        end else begin
            s1_valid      <= bus.pixel_valid;
            bus.out_valid <= s1_valid;
            if (bus.pixel_valid) begin
                px       <= n_px;
                py       <= n_py;
                sx       <= n_sx;
                sy       <= n_sy;
                cx       <= n_cx;
                cy       <= n_cy;
                s1_in    <= in_field;
                s1_panel <= in_panel;
                s1_idx   <= cell_idx;
`ifdef GRID_LINES_EN
                s1_edge  <= (e_sx == '0) || (e_sy == '0);
`endif
                if (bus.frame_start)
                    snapshot <= bus.field;
            end
            if (s1_valid)
                bus.bgr_data <= colour;
        end
    end

    task automatic bgr_reset();
        bus.bgr_data  <= 24'h000000;
        bus.out_valid <= 1'b0;
    endtask
endmodule
